adder_op_issuer: RTL and testbench

Drives the 9-bit operand interface of the adder and consumes its 10-bit result stream. Operand pairs are buffered in a small FIFO and issued under control of a start/count run sequencer. Each returned sum is checked against an in-flight expected value at the adder's fixed latency. The block sits on the initiator side of the adder's in_valid/data_in0/data_in1 → out_valid/data_out interface and reports pass/fail counts and sticky error flags.

---
 rtl/adder_op_issuer.sv | 244 ++++++++++++++++++++++++
 tb/tb_adder_op_issuer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_op_issuer.sv
// rtl/adder_op_issuer.sv - operand issuer and result checker for a fixed-latency adder
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid/cmd_ready      operand pair push into the operand FIFO
//   cmd_a, cmd_b             operand pair
//   start, num_ops           run start pulse and operation count (sampled in IDLE)
//   in_valid, data_in0/1     operand beat driven to the adder
//   out_valid, data_out      result beat returned by the adder
//   busy, done               run status and end-of-run pulse
//   pass_cnt, err_cnt        saturating match / error event counters
//   err_flags                sticky {spurious, missing, mismatch}
module adder_op_issuer #(
    parameter int WIDTH   = 9,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             start,
    input  logic [7:0]       num_ops,
    output logic             in_valid,
    output logic [WIDTH-1:0] data_in0,
    output logic [WIDTH-1:0] data_in1,
    input  logic             out_valid,
    input  logic [WIDTH:0]   data_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      err_cnt,
    output logic [2:0]       err_flags
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        fifo_count;
    logic [AW:0]        fifo_count_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Full is registered so cmd_ready never depends on a same-cycle pop.
    assign cmd_ready  = !fifo_full;
    assign fifo_empty = (fifo_count == '0);
    assign push       = cmd_valid && cmd_ready;

    always_comb begin
        fifo_count_next = fifo_count;
        if (push && !pop) begin
            fifo_count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            fifo_count_next = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count_next;
            fifo_full  <= (fifo_count_next == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_a, cmd_b};
        end
    end

    // ------------------------------------------------------------------
    // Expectation pipe: one stage per cycle of adder latency
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] pipe_v;
    logic [WIDTH:0]     pipe_d [LATENCY];
    logic               tap_v;
    logic [WIDTH:0]     tap_d;
    logic               pipe_ahead;

    assign tap_v = pipe_v[LATENCY-1];
    assign tap_d = pipe_d[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= in_valid;
            pipe_d[0] <= {1'b0, data_in0} + {1'b0, data_in1};
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Anything still upstream of the tap. The tap itself is checked in the
    // current cycle, so leaving DRAIN now puts done one cycle after it.
    always_comb begin
        pipe_ahead = in_valid;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_ahead = pipe_ahead | pipe_v[i];
        end
    end

    // ------------------------------------------------------------------
    // Run sequencer
    // ------------------------------------------------------------------
    logic [7:0] remaining;
    logic       run_start;

    assign run_start = (state == S_IDLE) && start;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (remaining == 8'd0) begin
                    state_next = S_DRAIN;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!pipe_ahead) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= 8'd0;
        end else if (run_start) begin
            remaining <= num_ops;
        end else if (pop) begin
            remaining <= remaining - 8'd1;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Issue register: data holds its last value between beats
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid <= 1'b0;
            data_in0 <= '0;
            data_in1 <= '0;
        end else begin
            in_valid <= pop;
            if (pop) begin
                data_in0 <= fifo_mem[rd_ptr][2*WIDTH-1:WIDTH];
                data_in1 <= fifo_mem[rd_ptr][WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result check at the pipe tap; the four cases are mutually exclusive
    // ------------------------------------------------------------------
    logic ev_pass;
    logic ev_mismatch;
    logic ev_missing;
    logic ev_spurious;
    logic ev_err;

    assign ev_pass     = tap_v && out_valid && (data_out == tap_d);
    assign ev_mismatch = tap_v && out_valid && (data_out != tap_d);
    assign ev_missing  = tap_v && !out_valid;
    assign ev_spurious = !tap_v && out_valid;
    assign ev_err      = ev_mismatch || ev_missing || ev_spurious;

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            pass_cnt  <= 16'd0;
            err_cnt   <= 16'd0;
            err_flags <= 3'b000;
        end else begin
            if (ev_pass && (pass_cnt != 16'hFFFF)) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            if (ev_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            err_flags <= err_flags | {ev_spurious, ev_missing, ev_mismatch};
        end
    end

endmodule

// File: tb/tb_adder_op_issuer.sv
// tb/tb_adder_op_issuer.sv - scoreboard bench for adder_op_issuer with a behavioural adder
module tb_adder_op_issuer;

    localparam int WIDTH   = 9;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             start = 1'b0;
    logic [7:0]       num_ops = 8'd0;
    logic             in_valid;
    logic [WIDTH-1:0] data_in0;
    logic [WIDTH-1:0] data_in1;
    logic             out_valid = 1'b0;
    logic [WIDTH:0]   data_out = '0;
    logic             busy;
    logic             done;
    logic [15:0]      pass_cnt;
    logic [15:0]      err_cnt;
    logic [2:0]       err_flags;

    int total = 0;
    int bad   = 0;

    logic [2*WIDTH-1:0] exp_q [$];

    int corrupt_beat   = 4;
    int drop_beat      = 7;
    bit inject_spurious = 1'b0;

    adder_op_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .out_valid (out_valid),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    // Behavioural adder, LATENCY=1, with planted faults on selected beats.
    always begin : adder_model
        int beat;
        logic sv;
        logic [WIDTH:0] sd;
        beat = 0;
        forever begin
            @(negedge clk);
            sv = (in_valid && (beat != drop_beat)) || inject_spurious;
            sd = {1'b0, data_in0} + {1'b0, data_in1};
            if (in_valid && beat == corrupt_beat) sd = sd - 1'b1;
            if (in_valid) beat++;
            @(posedge clk);
            #1;
            out_valid = sv;
            data_out  = sd;
        end
    end

    // Scoreboard monitor: every issued beat must match the next queued pair.
    always @(negedge clk) begin
        if (!rst && in_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected got=%0d,%0d want=none", data_in0, data_in1);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                if ({data_in0, data_in1} !== e) begin
                    bad++;
                    $display("FAIL issue_operands got=%0d,%0d want=%0d,%0d",
                             data_in0, data_in1, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One clock; a held cmd_valid that is accepted on this edge is logged.
    task automatic step();
        bit pend;
        pend = cmd_valid && cmd_ready && !rst;
        @(posedge clk);
        #1;
        if (pend) begin
            exp_q.push_back({cmd_a, cmd_b});
            cmd_valid = 1'b0;
        end
    endtask

    task automatic push(input int a, input int b);
        check("push_ready", int'(cmd_ready), 1);
        cmd_a = WIDTH'(a);
        cmd_b = WIDTH'(b);
        cmd_valid = 1'b1;
        step();
    endtask

    task automatic run(input string tag, input int n, input int ep, input int ee,
                       input int ef, output int cyc);
        int beats;
        bit seen;
        beats = 0;
        seen  = 1'b0;
        cyc   = 0;
        num_ops = 8'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        for (int i = 1; i <= 60 && !seen; i++) begin
            step();
            if (in_valid) beats++;
            if (done) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        check({tag, "_beats"}, beats, n);
        check({tag, "_pass"}, int'(pass_cnt), ep);
        check({tag, "_err"}, int'(err_cnt), ee);
        check({tag, "_flags"}, int'(err_flags), ef);
        step();
        check({tag, "_done_once"}, int'(done), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check({tag, "_in_valid"}, int'(in_valid), 0);
        check({tag, "_data_in0"}, int'(data_in0), 0);
        check({tag, "_data_in1"}, int'(data_in1), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass_cnt), 0);
        check({tag, "_err"}, int'(err_cnt), 0);
        check({tag, "_flags"}, int'(err_flags), 0);
    endtask

    initial begin : main
        int cyc;
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Clean run: 3+4=7, 511+511=1022, 0+0=0 (beats 0..2)
        push(3, 4);
        push(511, 511);
        push(0, 0);
        run("clean", 3, 3, 0, 0, cyc);

        // Beat 4 (511+511) comes back as 1021
        push(3, 4);
        push(511, 511);
        push(0, 0);
        run("mismatch", 3, 2, 1, 3'b001, cyc);

        // Beat 7 has no out_valid
        push(3, 4);
        push(511, 511);
        push(0, 0);
        run("missing", 3, 2, 1, 3'b010, cyc);

        // Extra out_valid while IDLE
        inject_spurious = 1'b1;
        step();
        inject_spurious = 1'b0;
        step();
        step();
        check("spurious_err", int'(err_cnt), 2);
        check("spurious_flags", int'(err_flags), 3'b110);
        check("spurious_pass", int'(pass_cnt), 2);

        // Fill the FIFO; the fifth pair waits on cmd_ready
        push(1, 2);
        push(100, 200);
        push(255, 256);
        push(511, 0);
        check("full_ready", int'(cmd_ready), 0);
        cmd_a = 9'd0;
        cmd_b = 9'd511;
        cmd_valid = 1'b1;
        step();
        check("full_hold_ready", int'(cmd_ready), 0);
        run("partial", 2, 2, 0, 0, cyc);
        check("partial_ready", int'(cmd_ready), 1);
        check("partial_accepted", int'(cmd_valid), 0);
        check("partial_queued", exp_q.size(), 3);
        run("rest", 3, 3, 0, 0, cyc);

        // Zero-length run
        run("zero", 0, 0, 0, 0, cyc);
        check("zero_latency_ok", int'(cyc <= 1 + LATENCY + 1), 1);

        // Reset in the middle of a run
        push(7, 8);
        push(9, 10);
        push(11, 12);
        num_ops = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        step();
        exp_q.delete();
        rst = 1'b0;
        step();
        step();
        check("post_rst_in_valid", int'(in_valid), 0);
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
